// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bf_pkg
//  Description : Definitions shared by the brainfuck core and its output path:
//                UART transmitter state encoding and the ASCII opcode bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package bf_pkg;

  // UART transmitter states. The encoding is fixed so that state values
  // stay the same between releases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Bits per UART character (8N1 framing).
  localparam int C_UART_DATA_BITS = 8;

  // Brainfuck opcodes as the core decodes them.
  localparam logic [7:0] C_OP_INC        = 8'h2B;  // '+'
  localparam logic [7:0] C_OP_DEC        = 8'h2D;  // '-'
  localparam logic [7:0] C_OP_LEFT       = 8'h3C;  // '<'
  localparam logic [7:0] C_OP_RIGHT      = 8'h3E;  // '>'
  localparam logic [7:0] C_OP_OUT        = 8'h2E;  // '.'
  localparam logic [7:0] C_OP_IN         = 8'h2C;  // ','
  localparam logic [7:0] C_OP_LOOP_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] C_OP_LOOP_CLOSE = 8'h5D;  // ']'

endpackage
`default_nettype wire

// File: rtl/stdout_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : stdout_uart_tx_if
//  Description : Character output bus from the processor core: one byte and
//                a one-cycle valid strobe per character.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stdout_uart_tx_if;

  logic [7:0] stdout;
  logic       stdout_en;

  // The processor core drives the bus.
  modport master (output stdout, output stdout_en);
  // The UART transmitter consumes the bus.
  modport slave  (input  stdout, input  stdout_en);

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous byte FIFO with a registered read port. A write
//                into a full FIFO is accepted only if a pop happens on the
//                same edge. There is no write-to-read bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  wire logic                   clk,
  input  wire logic                   reset,    // asynchronous, active low
  input  wire logic                   wr_en,
  input  wire logic [7:0]             wr_data,
  input  wire logic                   rd_en,
  output logic      [7:0]             rd_data,
  output logic      [$clog2(DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int                 C_AW   = $clog2(DEPTH);
  localparam logic [C_AW:0]      C_FULL = (C_AW + 1)'(DEPTH);

  logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]   count_q,  count_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [7:0]      mem_q [DEPTH];
  logic            do_push;
  logic            do_pop;

  // Push/pop qualification plus the next pointer, count and read-data values.
  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    do_pop    = rd_en && (count_q != '0);
    do_push   = wr_en && ((count_q != C_FULL) || do_pop);
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_d = do_pop  ? mem_q[rd_ptr_q] : rd_data_q;
    count_d   = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array. Reset is not needed because stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = (count_q == C_FULL);
  assign empty   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/stdout_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : stdout_uart_tx
//  Description : Buffers processor output bytes and sends them on a single
//                pin as 8N1 UART frames. Frames go out back to back while the
//                buffer has data. A sticky flag records dropped bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module stdout_uart_tx
  import bf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  wire logic                        clk,
  input  wire logic                        reset,   // asynchronous, active low
  stdout_uart_tx_if.slave                  cpu,
  output logic                             tx,
  output logic                             busy,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

  localparam logic [15:0] C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  C_LAST_BIT  = 3'(C_UART_DATA_BITS - 1);

  uart_state_e state_q,    state_d;
  logic [15:0] baud_q,     baud_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [7:0]  shift_q,    shift_d;
  logic        tx_q,       tx_d;
  logic        overflow_q, overflow_d;
  logic        bit_done;

  logic                         fifo_rd_en;
  logic [7:0]                   fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0]  fifo_cnt;
  logic                         fifo_full;
  logic                         fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cpu.stdout_en),
    .wr_data (cpu.stdout),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencer: next state, baud timing, shifter and registered tx level.
  // The popped byte appears on the FIFO read port after the pop edge. It is
  // loaded into the shifter at the end of the start bit, because no other pop
  // can happen during the start bit.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_rd_en = 1'b0;
    bit_done   = (baud_q == C_BAUD_LAST);

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          shift_d   = fifo_rd_data;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == C_LAST_BIT) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_d    = ST_START;
          end else begin
            state_d    = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    // A byte is dropped only when the FIFO is full and nothing leaves it on
    // the same edge.
    overflow_d = overflow_q | (cpu.stdout_en & fifo_full & ~fifo_rd_en);
  end

  // State, timing and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx         = tx_q;
  assign overflow   = overflow_q;
  assign fifo_count = fifo_cnt;
  assign busy       = (state_q != ST_IDLE) || (fifo_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_stdout_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stdout_uart_tx
//  Description : Self-checking bench for stdout_uart_tx (CLKS_PER_BIT=4,
//                FIFO_DEPTH=4). It logs the outputs at every falling edge and
//                checks them against hand-computed frames and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stdout_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LOGSZ = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  stdout_uart_tx_if u_if ();

  stdout_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (u_if),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge E (and until the next one) cyc == E.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output history, one sample per cycle, indexed by the preceding edge.
  logic       txlog   [LOGSZ];
  logic       busylog [LOGSZ];
  logic       ovflog  [LOGSZ];
  logic [2:0] cntlog  [LOGSZ];
  always @(negedge clk) begin
    if (cyc < LOGSZ) begin
      txlog[cyc]   <= tx;
      busylog[cyc] <= busy;
      ovflog[cyc]  <= overflow;
      cntlog[cyc]  <= fifo_count;
    end
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 is sent first
  } vec_t;
  vec_t vecs [5];

  logic [7:0] pbuf [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Compares 10*CPB logged tx samples, starting at edge 'start', with a frame.
  task automatic chk_frame(input string name, input int start, input logic [9:0] frame);
    logic [39:0] act;
    logic [39:0] exp;
    for (int i = 0; i < 10 * CPB; i++) begin
      act[i] = (start + i < LOGSZ) ? txlog[start + i] : 1'bx;
      exp[i] = frame[i / CPB];
    end
    chk(name, {24'd0, act}, {24'd0, exp});
  endtask

  // Counts the logged cycles in [from,to] where tx or busy is not as expected.
  task automatic chk_const(input string name, input int from, input int to,
                           input logic etx, input logic ebusy);
    int bad = 0;
    for (int i = from; i <= to; i++) begin
      if (txlog[i] !== etx || busylog[i] !== ebusy) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  // Pushes pbuf[0..n-1] on consecutive edges. Returns the first push edge and
  // leaves the bench at #1 after the last push edge.
  task automatic push_seq(input int n, output int first_edge);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      u_if.stdout_en = 1'b1;
      u_if.stdout    = pbuf[i];
      @(posedge clk); #1;
      if (i == 0) first_edge = cyc;
    end
    u_if.stdout_en = 1'b0;
    u_if.stdout    = 8'($urandom);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;

    vecs[0] = '{8'h41, 10'b1010000010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h5A, 10'b1010110100};

    reset          = 1'b0;
    u_if.stdout_en = 1'b0;
    u_if.stdout    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx",    64'(tx),         64'd1);
    chk("reset_busy",  64'(busy),       64'd0);
    chk("reset_ovf",   64'(overflow),   64'd0);
    chk("reset_count", 64'(fifo_count), 64'd0);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---- single frames from the vector table ----
    for (int v = 0; v < 5; v++) begin
      pbuf[0] = vecs[v].data;
      push_seq(1, n);
      chk($sformatf("v%0d_count_after_push", v), 64'(fifo_count), 64'd1);
      chk($sformatf("v%0d_busy_after_push", v),  64'(busy),       64'd1);
      chk($sformatf("v%0d_tx_before_start", v),  64'(tx),         64'd1);
      wait_until(n + 1);
      chk($sformatf("v%0d_tx_start", v),         64'(tx),         64'd0);
      chk($sformatf("v%0d_count_after_pop", v),  64'(fifo_count), 64'd0);
      wait_until(n + 42);
      chk_frame($sformatf("v%0d_frame", v), n + 1, vecs[v].frame);
      chk($sformatf("v%0d_busy_last", v),  64'(busylog[n + 40]), 64'd1);
      chk($sformatf("v%0d_busy_done", v),  64'(busylog[n + 41]), 64'd0);
      chk($sformatf("v%0d_tx_idle", v),    64'(tx),              64'd1);
    end

    // ---- back-to-back frames ----
    pbuf[0] = 8'h48;
    pbuf[1] = 8'h69;
    push_seq(2, n);
    wait_until(n + 82);
    chk("b2b_count_first",  64'(cntlog[n]),      64'd1);
    chk("b2b_count_pushpop", 64'(cntlog[n + 1]), 64'd1);
    chk("b2b_count_second_pop", 64'(cntlog[n + 41]), 64'd0);
    chk_frame("b2b_frame0", n + 1,  frame_of(8'h48));
    chk_frame("b2b_frame1", n + 41, frame_of(8'h69));
    chk("b2b_busy_last", 64'(busylog[n + 80]), 64'd1);
    chk("b2b_busy_done", 64'(busylog[n + 81]), 64'd0);

    // ---- overflow: six pushes into a four-entry FIFO ----
    for (int i = 0; i < 6; i++) pbuf[i] = 8'h30 + 8'(i);
    push_seq(6, n);
    wait_until(n + 203);
    chk("ovf_count_edge1", 64'(cntlog[n + 1]), 64'd1);
    chk("ovf_count_full",  64'(cntlog[n + 4]), 64'd4);
    chk("ovf_flag_before", 64'(ovflog[n + 4]), 64'd0);
    chk("ovf_flag_set",    64'(ovflog[n + 5]), 64'd1);
    chk("ovf_count_drop",  64'(cntlog[n + 5]), 64'd4);
    for (int k = 0; k < 5; k++) begin
      chk_frame($sformatf("ovf_frame%0d", k), n + 1 + 40 * k, frame_of(8'h30 + 8'(k)));
    end
    chk("ovf_busy_last", 64'(busylog[n + 200]), 64'd1);
    chk("ovf_busy_done", 64'(busylog[n + 201]), 64'd0);
    wait_until(n + 240);
    chk_const("ovf_no_sixth_frame", n + 201, n + 239, 1'b1, 1'b0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Clear the sticky flag.
    #3 reset = 1'b0;
    #1 chk("ovf_cleared_by_reset", 64'(overflow), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // ---- full FIFO plus a push on the edge that pops ----
    for (int i = 0; i < 5; i++) pbuf[i] = 8'h10 + 8'(i);
    push_seq(5, n);
    wait_until(n + 40);
    chk("full_count_before", 64'(fifo_count), 64'd4);
    u_if.stdout_en = 1'b1;
    u_if.stdout    = 8'h55;
    @(posedge clk); #1;
    u_if.stdout_en = 1'b0;
    u_if.stdout    = 8'($urandom);
    chk("full_pop_push_count", 64'(fifo_count), 64'd4);
    chk("full_pop_push_ovf",   64'(overflow),   64'd0);
    wait_until(n + 243);
    for (int k = 0; k < 5; k++) begin
      chk_frame($sformatf("full_frame%0d", k), n + 1 + 40 * k, frame_of(8'h10 + 8'(k)));
    end
    chk_frame("full_frame_55", n + 201, frame_of(8'h55));
    chk("full_busy_done", 64'(busylog[n + 241]), 64'd0);
    chk("full_ovf_end",   64'(overflow),          64'd0);

    // ---- reset during data bit 3 of 0xA5 with two bytes queued ----
    pbuf[0] = 8'hA5;
    pbuf[1] = 8'h11;
    pbuf[2] = 8'h22;
    push_seq(3, n);
    wait_until(n + 18);
    chk("rst_queued",   64'(cntlog[n + 2]),  64'd2);
    chk("rst_bit3_low", 64'(txlog[n + 17]),  64'd0);
    #3 reset = 1'b0;
    #1;
    chk("rst_async_tx",    64'(tx),         64'd1);
    chk("rst_async_busy",  64'(busy),       64'd0);
    chk("rst_async_count", 64'(fifo_count), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    m = cyc;
    wait_until(m + 61);
    chk_const("rst_no_resume", m, m + 60, 1'b1, 1'b0);

    // ---- idle noise on stdout with stdout_en low ----
    m = cyc;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) u_if.stdout = 8'bx;
      else            u_if.stdout = 8'($urandom);
      @(posedge clk); #1;
    end
    chk_const("noise_idle", m + 1, m + 99, 1'b1, 1'b0);
    chk("noise_count", 64'(fifo_count), 64'd0);
    chk("noise_busy",  64'(busy),       64'd0);
    chk("noise_tx",    64'(tx),         64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
